// File: rtl/memory_access.sv
// Memory-access stage of the non-pipelined LEGv8 datapath.
// Resolves the next-PC select for B, B.cond, CBZ and CBNZ, and runs load/store
// transactions on a 64-bit req/ack data-memory port through a three-state FSM.
module memory_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [63:0] alu_result,
    input  logic [63:0] read_data2,
    input  logic [63:0] pc,
    input  logic [63:0] branch_alu_result,
    input  logic        uncond_branch,
    input  logic        cond_branch,
    input  logic        cbz,
    input  logic        cbnz,
    input  logic [3:0]  cond,
    input  logic        alu_zero,
    input  logic        zero,
    input  logic        negative,
    input  logic        carry,
    input  logic        overflow,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic [63:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    // Last REQ cycle index before the request is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  be_q;
    logic [2:0]  lane_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        err_q;
    logic [63:0] rd_q;

    logic        cond_true;
    logic [2:0]  lane;
    logic        misaligned;
    logic        legal;
    logic [7:0]  size_mask;
    logic [7:0]  be_in;
    logic [63:0] wdata_in;
    logic [63:0] rdata_shifted;
    logic [63:0] load_val;
    logic        in_req;

    // Condition-code evaluation for B.cond from the registered NZCV flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:  cond_true = zero;
            4'd1:  cond_true = ~zero;
            4'd2:  cond_true = carry;
            4'd3:  cond_true = ~carry;
            4'd4:  cond_true = negative;
            4'd5:  cond_true = ~negative;
            4'd6:  cond_true = overflow;
            4'd7:  cond_true = ~overflow;
            4'd8:  cond_true = carry & ~zero;
            4'd9:  cond_true = ~(carry & ~zero);
            4'd10: cond_true = (negative == overflow);
            4'd11: cond_true = (negative != overflow);
            4'd12: cond_true = ~zero & (negative == overflow);
            4'd13: cond_true = ~(~zero & (negative == overflow));
            default: cond_true = 1'b1;
        endcase
    end

    assign pc_src = uncond_branch | (cbz & alu_zero) | (cbnz & ~alu_zero)
                  | (cond_branch & cond_true);
    assign branch_target = pc_src ? branch_alu_result : (pc + 64'd4);

    // Lane placement, byte enables and alignment check for the incoming request.
    always_comb begin
        lane       = alu_result[2:0];
        misaligned = 1'b0;
        size_mask  = 8'h01;
        case (mem_size)
            2'b00: begin size_mask = 8'h01; misaligned = 1'b0;              end
            2'b01: begin size_mask = 8'h03; misaligned = lane[0];           end
            2'b10: begin size_mask = 8'h0F; misaligned = |lane[1:0];        end
            default: begin size_mask = 8'hFF; misaligned = |lane;           end
        endcase
        be_in    = size_mask << lane;
        wdata_in = read_data2 << {lane, 3'b000};
        legal    = (mem_read ^ mem_write) & ~misaligned;
    end

    // Load data extraction from the latched lane and size.
    always_comb begin
        rdata_shifted = dmem_rdata >> {lane_q, 3'b000};
        load_val      = '0;
        case (size_q)
            2'b00:   load_val = {56'd0, rdata_shifted[7:0]};
            2'b01:   load_val = {48'd0, rdata_shifted[15:0]};
            2'b10:   load_val = {32'd0, rdata_shifted[31:0]};
            default: load_val = rdata_shifted;
        endcase
    end

    // Transaction FSM with latched request fields, timeout counter and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            addr_q  <= {alu_result[63:3], 3'b000};
                            wdata_q <= wdata_in;
                            be_q    <= be_in;
                            lane_q  <= lane;
                            size_q  <= mem_size;
                            we_q    <= mem_write;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (!we_q) begin
                            rd_q <= load_val;
                        end
                        state_q <= RESP;
                    end else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_req     = (state_q == REQ);
    assign dmem_req   = in_req;
    assign dmem_we    = in_req & we_q;
    assign dmem_addr  = in_req ? addr_q  : '0;
    assign dmem_wdata = in_req ? wdata_q : '0;
    assign dmem_be    = in_req ? be_q    : '0;
    assign stall      = ((state_q == IDLE) & start) | in_req;
    assign done       = (state_q == RESP);
    assign error      = (state_q == RESP) & err_q;
    assign read_data  = rd_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// transactions and branch vectors checked against a behavioural model.
module tb_memory_access;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [63:0] alu_result, read_data2, pc, branch_alu_result;
    logic        uncond_branch, cond_branch, cbz, cbnz;
    logic [3:0]  cond;
    logic        alu_zero, zero, negative, carry, overflow;
    logic        pc_src;
    logic [63:0] branch_target, read_data;
    logic        stall, done, error;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .alu_result(alu_result),
        .read_data2(read_data2), .pc(pc), .branch_alu_result(branch_alu_result),
        .uncond_branch(uncond_branch), .cond_branch(cond_branch), .cbz(cbz),
        .cbnz(cbnz), .cond(cond), .alu_zero(alu_zero), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow),
        .pc_src(pc_src), .branch_target(branch_target), .read_data(read_data),
        .stall(stall), .done(done), .error(error), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic z, input logic n,
                                        input logic cy, input logic v);
        logic r;
        case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !(cy && !z);
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z && (n == v);
            4'd13: r = !(!z && (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check_branch(input string tag);
        logic        exp_src;
        logic [63:0] exp_tgt;
        #1;
        exp_src = uncond_branch || (cbz && alu_zero) || (cbnz && !alu_zero)
               || (cond_branch && cond_holds(cond, zero, negative, carry, overflow));
        exp_tgt = exp_src ? branch_alu_result : pc + 64'd4;
        check_eq({tag, "_pc_src"}, 64'(pc_src), 64'(exp_src));
        check_eq({tag, "_target"}, branch_target, exp_tgt);
    endtask

    // Called at posedge+1 with the FSM idle; returns at posedge+1 with the FSM idle.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rdata, input int unsigned ack_delay);
        int unsigned n, lane;
        bit          legal, acked;
        logic [63:0] exp_load, exp_wd, exp_addr;
        logic [7:0]  exp_be;
        n        = 1 << sz;
        lane     = int'(addr[2:0]);
        legal    = (rd != wr) && (lane % n == 0);
        exp_addr = addr & ~64'h7;
        exp_be   = 8'(((64'd1 << n) - 64'd1) << lane);
        exp_wd   = wd << (8 * lane);
        exp_load = '0;
        if (legal)
            for (int b = 0; b < int'(n); b++)
                exp_load[8*b +: 8] = rdata[8*(int'(lane) + b) +: 8];

        start = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        alu_result = addr; read_data2 = wd;
        #1;
        check_eq("c0_stall", 64'(stall), 64'd1);
        check_eq("c0_req", 64'(dmem_req), 64'd0);
        check_eq("c0_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        alu_result = {$urandom, $urandom}; read_data2 = {$urandom, $urandom};
        mem_size = 2'($urandom);
        #1;
        if (!legal) begin
            check_eq("ill_done", 64'(done), 64'd1);
            check_eq("ill_error", 64'(error), 64'd1);
            check_eq("ill_req", 64'(dmem_req), 64'd0);
            check_eq("ill_stall", 64'(stall), 64'd0);
            check_eq("ill_rd", read_data, exp_rd);
            @(posedge clk); #1;
            check_eq("ill_done_end", 64'(done), 64'd0);
            return;
        end
        acked = 1'b0;
        for (int unsigned k = 0; k < TO; k++) begin
            check_eq("req_req", 64'(dmem_req), 64'd1);
            check_eq("req_stall", 64'(stall), 64'd1);
            check_eq("req_done", 64'(done), 64'd0);
            check_eq("req_we", 64'(dmem_we), 64'(wr));
            check_eq("req_addr", dmem_addr, exp_addr);
            if (wr) begin
                check_eq("req_be", 64'(dmem_be), 64'(exp_be));
                check_eq("req_wdata", dmem_wdata, exp_wd);
            end
            if (k == ack_delay) begin
                dmem_ack = 1'b1; dmem_rdata = rdata; acked = 1'b1;
            end else begin
                dmem_rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            #1;
            if (acked) break;
        end
        if (acked && rd) exp_rd = exp_load;
        check_eq("resp_done", 64'(done), 64'd1);
        check_eq("resp_error", 64'(error), 64'(!acked));
        check_eq("resp_req", 64'(dmem_req), 64'd0);
        check_eq("resp_stall", 64'(stall), 64'd0);
        check_eq("resp_rd", read_data, exp_rd);
        @(posedge clk); #1;
        check_eq("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [63:0] addr;
        logic        rd, wr;
        int unsigned sel;

        reset = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = '0;
        alu_result = '0; read_data2 = '0; pc = '0; branch_alu_result = '0;
        uncond_branch = 1'b0; cond_branch = 1'b0; cbz = 1'b0; cbnz = 1'b0; cond = '0;
        alu_zero = 1'b0; zero = 1'b0; negative = 1'b0; carry = 1'b0; overflow = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        exp_rd = '0;
        #2;
        check_eq("rst_req", 64'(dmem_req), 64'd0);
        check_eq("rst_we", 64'(dmem_we), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_be", 64'(dmem_be), 64'd0);
        check_eq("rst_addr", dmem_addr, 64'd0);
        check_eq("rst_wdata", dmem_wdata, 64'd0);
        check_eq("rst_rd", read_data, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 1'b0, 2'b11, 64'h1000, 64'd0, 64'hDEADBEEF_CAFEF00D, 0);
        run_txn(1'b0, 1'b1, 2'b00, 64'h1003, 64'hAB, 64'd0, 1);
        run_txn(1'b1, 1'b0, 2'b01, 64'h2006, 64'd0, 64'h1234_5678_9ABC_DEF0, 2);
        run_txn(1'b1, 1'b0, 2'b10, 64'h1002, 64'd0, 64'd0, 0);
        run_txn(1'b1, 1'b0, 2'b11, 64'h3000, 64'd0, 64'h5555_6666_7777_8888, 99);
        run_txn(1'b1, 1'b0, 2'b10, 64'h4004, 64'd0, 64'hA1B2C3D4_E5F60718, TO - 1);
        run_txn(1'b0, 1'b0, 2'b00, 64'h5000, 64'd0, 64'd0, 0);
        run_txn(1'b1, 1'b1, 2'b00, 64'h5000, 64'd0, 64'd0, 0);

        // Acknowledge while idle must not start or finish anything.
        dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check_eq("stray_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check_eq("stray_done", 64'(done), 64'd0);
        check_eq("stray_req", 64'(dmem_req), 64'd0);
        check_eq("stray_rd", read_data, exp_rd);

        for (int i = 0; i < 60; i++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << sz) - 1);
            sel = $urandom_range(0, 9);
            if (sel == 0)      begin rd = 1'b0; wr = 1'b0; end
            else if (sel == 1) begin rd = 1'b1; wr = 1'b1; end
            else begin rd = 1'($urandom); wr = !rd; end
            run_txn(rd, wr, sz, addr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 5));
        end

        // Reset during REQ: request and stall drop at once, no done follows.
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b11;
        alu_result = 64'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check_eq("mid_req_before", 64'(dmem_req), 64'd1);
        reset = 1'b0;
        #1;
        exp_rd = '0;
        check_eq("mid_req", 64'(dmem_req), 64'd0);
        check_eq("mid_stall", 64'(stall), 64'd0);
        check_eq("mid_done", 64'(done), 64'd0);
        check_eq("mid_rd", read_data, exp_rd);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_done_after", 64'(done), 64'd0);
        check_eq("mid_req_after", 64'(dmem_req), 64'd0);

        // Branch resolution.
        pc = 64'h400; branch_alu_result = 64'h800;
        cond_branch = 1'b1; cond = 4'd12; negative = 1'b1; overflow = 1'b1; zero = 1'b0;
        check_branch("gt");
        cond_branch = 1'b0; cbnz = 1'b1; alu_zero = 1'b1;
        check_branch("cbnz");
        check_eq("cbnz_fallthrough", branch_target, 64'h404);
        for (int i = 0; i < 200; i++) begin
            pc = {$urandom, $urandom}; branch_alu_result = {$urandom, $urandom};
            uncond_branch = ($urandom_range(0, 5) == 0);
            cond_branch = 1'($urandom); cbz = ($urandom_range(0, 3) == 0);
            cbnz = ($urandom_range(0, 3) == 0); cond = 4'($urandom);
            alu_zero = 1'($urandom); zero = 1'($urandom); negative = 1'($urandom);
            carry = 1'($urandom); overflow = 1'($urandom);
            check_branch("rand_br");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
